scale_arb_mux: RTL and testbench

Parametrised N-channel, WIDTH-bit multiplexer with a valid/ready handshake on every input and on the output. It arbitrates among requesting channels in either fixed-priority or round-robin mode. The winning channel's data is captured into a single registered output stage. It is the clocked, multi-channel successor to the team's combinational 2:1 scale mux and sits between parallel producers and a shared downstream datapath.

---
 rtl/scale_arb_mux.sv | 79 +++++++
 tb/tb_scale_arb_mux.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scale_arb_mux.sv
// N-channel valid/ready arbiter-multiplexer with one registered output stage.
// Fixed-priority or round-robin winner selection; the RR pointer tracks every transfer.
module scale_arb_mux #(
  parameter  int WIDTH = 8,
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode_rr,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_sel
);

  localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] win_sel;
  logic [SEL_W-1:0] next_ptr;
  logic [SEL_W:0]   cand_ext;
  logic [N_CH-1:0]  grant;
  logic [WIDTH-1:0] win_data;
  logic             found;
  logic             load;

  // Fixed priority is a round-robin search that always starts at channel 0.
  always_comb begin
    grant    = '0;
    win_sel  = '0;
    found    = 1'b0;
    cand_ext = '0;
    base     = mode_rr ? rr_ptr : '0;
    for (int k = 0; k < N_CH; k++) begin
      cand_ext = {1'b0, base} + k[SEL_W:0];
      if (cand_ext >= N_CH_EXT) cand_ext = cand_ext - N_CH_EXT;
      if (!found && in_valid[cand_ext[SEL_W-1:0]]) begin
        found   = 1'b1;
        win_sel = cand_ext[SEL_W-1:0];
      end
    end
    if (found) grant[win_sel] = 1'b1;
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant[k]) win_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign next_ptr = (win_sel == LAST_CH) ? '0 : win_sel + SEL_W'(1);
  assign load     = !out_valid || out_ready;
  assign in_ready = (load && !rst) ? grant : '0;

  // A pop and a fresh accept can share an edge, giving back-to-back words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= found;
      if (found) begin
        out_data <= win_data;
        out_sel  <= win_sel;
        rr_ptr   <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_scale_arb_mux.sv
// Scoreboard bench for scale_arb_mux: a 4-channel and a 3-channel instance
// driven from directed vector tables, outputs checked by a decoupled monitor.
module tb_scale_arb_mux;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_mode_rr;
  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid;
  logic [3:0]  a_in_ready;
  logic [7:0]  a_out_data;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [1:0]  a_out_sel;

  logic        b_mode_rr;
  logic [23:0] b_in_data;
  logic [2:0]  b_in_valid;
  logic [2:0]  b_in_ready;
  logic [7:0]  b_out_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [1:0]  b_out_sel;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [3:0]  vld;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        chk_ov;
    logic        exp_ov;
    logic        push;
    logic [7:0]  exp_d;
    logic [1:0]  exp_s;
  } vec_t;

  vec_t       va[$];
  vec_t       vb[$];
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  logic [9:0] a_e;
  logic [9:0] b_e;
  int         vectors = 0;
  int         fails   = 0;

  localparam logic [31:0] DA = 32'hA3A2A1A0;
  localparam logic [31:0] DF = 32'h33A211A0;
  localparam logic [31:0] DC = 32'h00C2C1C0;

  scale_arb_mux #(.WIDTH(8), .N_CH(4)) dut_a (
    .clk(clk), .rst(rst), .mode_rr(a_mode_rr),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sel(a_out_sel)
  );

  scale_arb_mux #(.WIDTH(8), .N_CH(3)) dut_b (
    .clk(clk), .rst(rst), .mode_rr(b_mode_rr),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sel(b_out_sel)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic m, logic [3:0] v, logic [31:0] d, logic o,
                              logic [3:0] er, logic cov, logic eov, logic p,
                              logic [7:0] ed, logic [1:0] es);
    vec_t t;
    t.rst = r; t.mode = m; t.vld = v; t.data = d; t.ordy = o;
    t.exp_rdy = er; t.chk_ov = cov; t.exp_ov = eov; t.push = p;
    t.exp_d = ed; t.exp_s = es;
    return t;
  endfunction

  // Drive one vector just after the rising edge, queue its expected word, then
  // wait for the falling edge so the caller can sample settled outputs.
  task automatic applyStimulus(input vec_t v, input bit to_b);
    @(posedge clk);
    #1;
    rst = v.rst;
    if (!to_b) begin
      a_mode_rr   = v.mode;
      a_in_valid  = v.vld;
      a_in_data   = v.data;
      a_out_ready = v.ordy;
      if (v.push) exp_a.push_back({v.exp_s, v.exp_d});
    end else begin
      b_mode_rr   = v.mode;
      b_in_valid  = v.vld[2:0];
      b_in_data   = v.data[23:0];
      b_out_ready = v.ordy;
      if (v.push) exp_b.push_back({v.exp_s, v.exp_d});
    end
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input vec_t v,
                             input logic [3:0] got_rdy, input logic got_ov);
    vectors++;
    if (got_rdy !== v.exp_rdy) begin
      fails++;
      $display("[TB] FAIL %s_in_ready got=%b required=%b", name, got_rdy, v.exp_rdy);
    end
    if (v.chk_ov) begin
      vectors++;
      if (got_ov !== v.exp_ov) begin
        fails++;
        $display("[TB] FAIL %s_out_valid got=%b required=%b", name, got_ov, v.exp_ov);
      end
    end
  endtask

  // Monitor: every word the DUT hands downstream is popped from its queue.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      vectors++;
      if (exp_a.size() == 0) begin
        fails++;
        $display("[TB] FAIL a_unexpected_word got sel=%0d data=%h required none", a_out_sel, a_out_data);
      end else begin
        a_e = exp_a.pop_front();
        if ({a_out_sel, a_out_data} !== a_e)
          begin
            fails++;
            $display("[TB] FAIL a_word got sel=%0d data=%h required sel=%0d data=%h",
                     a_out_sel, a_out_data, a_e[9:8], a_e[7:0]);
          end
      end
    end
    if (!rst && b_out_valid && b_out_ready) begin
      vectors++;
      if (exp_b.size() == 0) begin
        fails++;
        $display("[TB] FAIL b_unexpected_word got sel=%0d data=%h required none", b_out_sel, b_out_data);
      end else begin
        b_e = exp_b.pop_front();
        if ({b_out_sel, b_out_data} !== b_e)
          begin
            fails++;
            $display("[TB] FAIL b_word got sel=%0d data=%h required sel=%0d data=%h",
                     b_out_sel, b_out_data, b_e[9:8], b_e[7:0]);
          end
      end
    end
  end

  logic [3:0]  a_pend;
  logic [31:0] a_held;
  logic [2:0]  b_pend;
  logic [23:0] b_held;
  logic        a_stall_q;
  logic        b_stall_q;
  logic [9:0]  a_hold_q;
  logic [9:0]  b_hold_q;

  // Protocol watchers: one-hot ready, output hold under stall, stable pending inputs.
  always @(negedge clk) begin
    if (!$onehot0(a_in_ready)) begin
      fails++;
      $display("[TB] FAIL a_ready_onehot got=%b required at most one bit", a_in_ready);
    end
    if (!$onehot0(b_in_ready)) begin
      fails++;
      $display("[TB] FAIL b_ready_onehot got=%b required at most one bit", b_in_ready);
    end
    if (b_out_valid && b_out_sel == 2'd3) begin
      fails++;
      $display("[TB] FAIL b_sel_range got=%0d required <=2", b_out_sel);
    end
    if (!rst && a_stall_q && {a_out_sel, a_out_data} !== a_hold_q) begin
      fails++;
      $display("[TB] FAIL a_stall_hold got=%h required=%h", {a_out_sel, a_out_data}, a_hold_q);
    end
    if (!rst && b_stall_q && {b_out_sel, b_out_data} !== b_hold_q) begin
      fails++;
      $display("[TB] FAIL b_stall_hold got=%h required=%h", {b_out_sel, b_out_data}, b_hold_q);
    end
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (a_pend[i] && (!a_in_valid[i] || a_in_data[i*8 +: 8] != a_held[i*8 +: 8])) begin
          fails++;
          $display("[TB] FAIL a_input_protocol ch%0d got valid=%b data=%h required valid=1 data=%h",
                   i, a_in_valid[i], a_in_data[i*8 +: 8], a_held[i*8 +: 8]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (b_pend[i] && (!b_in_valid[i] || b_in_data[i*8 +: 8] != b_held[i*8 +: 8])) begin
          fails++;
          $display("[TB] FAIL b_input_protocol ch%0d got valid=%b data=%h required valid=1 data=%h",
                   i, b_in_valid[i], b_in_data[i*8 +: 8], b_held[i*8 +: 8]);
        end
      end
    end
    a_pend    <= rst ? 4'b0 : (a_in_valid & ~a_in_ready);
    b_pend    <= rst ? 3'b0 : (b_in_valid & ~b_in_ready);
    a_held    <= a_in_data;
    b_held    <= b_in_data;
    a_stall_q <= !rst && a_out_valid && !a_out_ready;
    b_stall_q <= !rst && b_out_valid && !b_out_ready;
    a_hold_q  <= {a_out_sel, a_out_data};
    b_hold_q  <= {b_out_sel, b_out_data};
  end

  initial begin
    rst = 1'b1;
    a_mode_rr = 1'b0; a_in_data = '0; a_in_valid = '0; a_out_ready = 1'b1;
    b_mode_rr = 1'b0; b_in_data = '0; b_in_valid = '0; b_out_ready = 1'b1;
    a_pend = '0; b_pend = '0; a_held = '0; b_held = '0;
    a_stall_q = 1'b0; b_stall_q = 1'b0; a_hold_q = '0; b_hold_q = '0;

    // 4-channel: reset, RR clean-up, fixed priority, RR fairness, drain,
    // backpressure, wrap, reset mid-stream.
    va.push_back(mk(1, 0, 4'hF, DA, 1, 4'h0, 1, 0, 0, 8'h00, 2'd0));
    va.push_back(mk(1, 0, 4'hF, DA, 1, 4'h0, 1, 0, 0, 8'h00, 2'd0));
    va.push_back(mk(0, 0, 4'hF, DA, 1, 4'h1, 1, 0, 1, 8'hA0, 2'd0));
    va.push_back(mk(0, 1, 4'hE, DA, 1, 4'h2, 1, 1, 1, 8'hA1, 2'd1));
    va.push_back(mk(0, 1, 4'hC, DA, 1, 4'h4, 0, 0, 1, 8'hA2, 2'd2));
    va.push_back(mk(0, 1, 4'h8, DA, 1, 4'h8, 0, 0, 1, 8'hA3, 2'd3));
    va.push_back(mk(0, 0, 4'hA, DF, 1, 4'h2, 1, 1, 1, 8'h11, 2'd1));
    va.push_back(mk(0, 0, 4'hA, DF, 1, 4'h2, 1, 1, 1, 8'h11, 2'd1));
    va.push_back(mk(0, 0, 4'hA, DF, 1, 4'h2, 1, 1, 1, 8'h11, 2'd1));
    va.push_back(mk(0, 1, 4'h8, DF, 1, 4'h8, 0, 0, 1, 8'h33, 2'd3));
    va.push_back(mk(0, 1, 4'hF, DA, 1, 4'h1, 1, 1, 1, 8'hA0, 2'd0));
    va.push_back(mk(0, 1, 4'hF, DA, 1, 4'h2, 1, 1, 1, 8'hA1, 2'd1));
    va.push_back(mk(0, 1, 4'hF, DA, 1, 4'h4, 1, 1, 1, 8'hA2, 2'd2));
    va.push_back(mk(0, 1, 4'hF, DA, 1, 4'h8, 1, 1, 1, 8'hA3, 2'd3));
    va.push_back(mk(0, 1, 4'hF, DA, 1, 4'h1, 1, 1, 1, 8'hA0, 2'd0));
    va.push_back(mk(0, 1, 4'hE, DA, 1, 4'h2, 1, 1, 1, 8'hA1, 2'd1));
    va.push_back(mk(0, 1, 4'hC, DA, 1, 4'h4, 0, 0, 1, 8'hA2, 2'd2));
    va.push_back(mk(0, 1, 4'h8, DA, 1, 4'h8, 0, 0, 1, 8'hA3, 2'd3));
    va.push_back(mk(0, 1, 4'h0, DA, 1, 4'h0, 1, 1, 0, 8'h00, 2'd0));
    va.push_back(mk(0, 1, 4'h0, DA, 1, 4'h0, 1, 0, 0, 8'h00, 2'd0));
    va.push_back(mk(0, 1, 4'h5, DA, 1, 4'h1, 1, 0, 1, 8'hA0, 2'd0));
    va.push_back(mk(0, 1, 4'h5, DA, 0, 4'h0, 1, 1, 0, 8'h00, 2'd0));
    va.push_back(mk(0, 1, 4'h5, DA, 0, 4'h0, 1, 1, 0, 8'h00, 2'd0));
    va.push_back(mk(0, 1, 4'h5, DA, 0, 4'h0, 1, 1, 0, 8'h00, 2'd0));
    va.push_back(mk(0, 1, 4'h5, DA, 1, 4'h4, 1, 1, 1, 8'hA2, 2'd2));
    va.push_back(mk(0, 1, 4'h1, DA, 1, 4'h1, 1, 1, 1, 8'hA0, 2'd0));
    va.push_back(mk(0, 1, 4'h0, DA, 1, 4'h0, 1, 1, 0, 8'h00, 2'd0));
    va.push_back(mk(0, 1, 4'hF, DA, 1, 4'h2, 1, 0, 1, 8'hA1, 2'd1));
    va.push_back(mk(0, 1, 4'hF, DA, 1, 4'h4, 1, 1, 0, 8'h00, 2'd0));
    va.push_back(mk(1, 1, 4'hF, DA, 1, 4'h0, 1, 0, 0, 8'h00, 2'd0));
    va.push_back(mk(0, 1, 4'hF, DA, 1, 4'h1, 1, 0, 1, 8'hA0, 2'd0));
    va.push_back(mk(0, 1, 4'hE, DA, 1, 4'h2, 1, 1, 1, 8'hA1, 2'd1));
    va.push_back(mk(0, 1, 4'hC, DA, 1, 4'h4, 0, 0, 1, 8'hA2, 2'd2));
    va.push_back(mk(0, 1, 4'h8, DA, 1, 4'h8, 0, 0, 1, 8'hA3, 2'd3));
    va.push_back(mk(0, 1, 4'h0, DA, 1, 4'h0, 1, 1, 0, 8'h00, 2'd0));
    va.push_back(mk(0, 1, 4'h0, DA, 1, 4'h0, 1, 0, 0, 8'h00, 2'd0));

    // 3-channel: pointer wraps 2 -> 0 in both modes, sparse requests.
    vb.push_back(mk(0, 1, 4'h7, DC, 1, 4'h1, 1, 0, 1, 8'hC0, 2'd0));
    vb.push_back(mk(0, 1, 4'h6, DC, 1, 4'h2, 1, 1, 1, 8'hC1, 2'd1));
    vb.push_back(mk(0, 1, 4'h4, DC, 1, 4'h4, 0, 0, 1, 8'hC2, 2'd2));
    vb.push_back(mk(0, 1, 4'h7, DC, 1, 4'h1, 1, 1, 1, 8'hC0, 2'd0));
    vb.push_back(mk(0, 1, 4'h6, DC, 1, 4'h2, 0, 0, 1, 8'hC1, 2'd1));
    vb.push_back(mk(0, 1, 4'h5, DC, 1, 4'h4, 0, 0, 1, 8'hC2, 2'd2));
    vb.push_back(mk(0, 1, 4'h1, DC, 1, 4'h1, 0, 0, 1, 8'hC0, 2'd0));
    vb.push_back(mk(0, 0, 4'h6, DC, 1, 4'h2, 0, 0, 1, 8'hC1, 2'd1));
    vb.push_back(mk(0, 0, 4'h4, DC, 1, 4'h4, 0, 0, 1, 8'hC2, 2'd2));
    vb.push_back(mk(0, 1, 4'h3, DC, 1, 4'h1, 0, 0, 1, 8'hC0, 2'd0));
    vb.push_back(mk(0, 1, 4'h2, DC, 1, 4'h2, 0, 0, 1, 8'hC1, 2'd1));
    vb.push_back(mk(0, 1, 4'h0, DC, 1, 4'h0, 1, 1, 0, 8'h00, 2'd0));
    vb.push_back(mk(0, 1, 4'h0, DC, 1, 4'h0, 1, 0, 0, 8'h00, 2'd0));

    foreach (va[i]) begin
      applyStimulus(va[i], 1'b0);
      checkOutput($sformatf("a_row%0d", i), va[i], a_in_ready, a_out_valid);
    end
    foreach (vb[i]) begin
      applyStimulus(vb[i], 1'b1);
      checkOutput($sformatf("b_row%0d", i), vb[i], {1'b0, b_in_ready}, b_out_valid);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (exp_a.size() != 0) begin
      fails++;
      $display("[TB] FAIL a_words_missing got=%0d left required=0", exp_a.size());
    end
    vectors++;
    if (exp_b.size() != 0) begin
      fails++;
      $display("[TB] FAIL b_words_missing got=%0d left required=0", exp_b.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
